shift_sub_div: RTL and testbench



---
 rtl/shift_sub_div_if.sv | 24 ++
 rtl/shift_sub_div.sv | 146 ++++++++++++++
 tb/tb_shift_sub_div.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/shift_sub_div_if.sv
// Request/result bundle for the shift-and-subtract divider.
// The master drives the operands and start; the slave returns the results and status.
interface shift_sub_div_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         finish;
    logic         busy;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, finish, busy, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, finish, busy, div_by_zero
    );
endinterface

// File: rtl/shift_sub_div.sv
// Sequential restoring (shift-and-subtract) divider: one quotient bit per clock.
// A start accepted at edge k raises finish after edge k+N, or after edge k+1 for a zero divisor.
// Optional macro SHIFT_SUB_DIV_SIGNED_EN: two's complement operands; the unsigned core
// divides magnitudes and the result edge applies sign correction (truncation toward zero).
module shift_sub_div #(
    parameter int unsigned N = 32
) (
    input  logic           clk,
    input  logic           reset,
    shift_sub_div_if.slave bus
);
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [N-1:0]  q_q;          // dividend shifting out / quotient shifting in
    logic [N-1:0]  d_q;          // captured divisor (magnitude)
    logic [N-1:0]  r_q;          // partial remainder; always < divisor, so N bits suffice
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  quotient_q;
    logic [N-1:0]  remainder_q;
    logic          finish_q;
    logic          busy_q;
    logic          dbz_q;

    logic [N:0]    r_shift_c;
    logic          ge_c;
    logic [N-1:0]  r_d;
    logic [N-1:0]  q_d;
    logic [N-1:0]  a_mag_c;
    logic [N-1:0]  b_mag_c;
    logic [N-1:0]  quo_fin_c;
    logic [N-1:0]  rem_fin_c;
    logic [N-1:0]  rem_dbz_c;
    logic          accept_c;
    logic          last_c;

`ifdef SHIFT_SUB_DIV_SIGNED_EN
    logic          sa_q;         // dividend was negative
    logic          sb_q;         // divisor was negative
`endif

    // A new operation is taken when idle or on the cycle finish is presented.
    assign accept_c = bus.start && ((state_q == IDLE) || ((state_q == DONE) && finish_q));
    assign last_c   = (cnt_q == CW'(N - 1));

    // One restoring iteration: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        r_shift_c = {r_q, q_q[N-1]};
        ge_c      = (r_shift_c >= {1'b0, d_q});
        r_d       = ge_c ? (r_shift_c[N-1:0] - d_q) : r_shift_c[N-1:0];
        q_d       = {q_q[N-2:0], ge_c};
    end

    // Operand conditioning at capture and result correction at completion.
    always_comb begin
`ifdef SHIFT_SUB_DIV_SIGNED_EN
        a_mag_c   = bus.dividend[N-1] ? (~bus.dividend + N'(1)) : bus.dividend;
        b_mag_c   = bus.divisor[N-1]  ? (~bus.divisor  + N'(1)) : bus.divisor;
        quo_fin_c = (sa_q ^ sb_q) ? (~q_d + N'(1)) : q_d;
        rem_fin_c = sa_q ? (~r_d + N'(1)) : r_d;
        rem_dbz_c = sa_q ? (~q_q + N'(1)) : q_q;
`else
        a_mag_c   = bus.dividend;
        b_mag_c   = bus.divisor;
        quo_fin_c = q_d;
        rem_fin_c = r_d;
        rem_dbz_c = q_q;
`endif
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            finish_q    <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef SHIFT_SUB_DIV_SIGNED_EN
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
`endif
        end else if (accept_c) begin
            q_q      <= a_mag_c;
            d_q      <= b_mag_c;
            r_q      <= '0;
            cnt_q    <= '0;
            finish_q <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef SHIFT_SUB_DIV_SIGNED_EN
            sa_q     <= bus.dividend[N-1];
            sb_q     <= bus.divisor[N-1];
`endif
            if (bus.divisor == '0) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
            end else begin
                state_q <= RUN;
                busy_q  <= 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_c) begin
                        quotient_q  <= quo_fin_c;
                        remainder_q <= rem_fin_c;
                        finish_q    <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (finish_q) begin
                        finish_q <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        // zero divisor: skip RUN and present the fixed result one edge later
                        quotient_q  <= '1;
                        remainder_q <= rem_dbz_c;
                        dbz_q       <= 1'b1;
                        finish_q    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.finish      = finish_q;
    assign bus.busy        = busy_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_div.sv
// Scoreboard bench for shift_sub_div (unsigned build, N=16).
// Stimulus pushes the arithmetic result and the expected finish cycle; a monitor pops on finish.
module tb_shift_sub_div;
    localparam int unsigned N = 16;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int unsigned  fin;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sbq[$];
    exp_t        mon_e;

    shift_sub_div_if #(.N(N)) bus ();

    shift_sub_div #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every finish pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.finish === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_finish at cycle %0d: got q=%0h r=%0h expected no finish",
                         cyc, bus.quotient, bus.remainder);
            end else begin
                mon_e = sbq.pop_front();
                check("quotient",     64'(bus.quotient),    64'(mon_e.q));
                check("remainder",    64'(bus.remainder),   64'(mon_e.r));
                check("div_by_zero",  64'(bus.div_by_zero), 64'(mon_e.dz));
                check("finish_cycle", 64'(cyc),             64'(mon_e.fin));
            end
        end
    end

    // Issue one operation at the current negedge; returns at the negedge where finish is visible.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input int unsigned gap, input bit spur, input bit hold);
        exp_t e;
        int unsigned acc;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        acc = cyc + 1;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.fin = acc + 1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dz  = 1'b0;
            e.fin = acc + N;
        end
        sbq.push_back(e);
        @(negedge clk);
        check("busy_after_start", 64'(bus.busy), 64'(b != '0));
        while (cyc < e.fin) begin
            bus.start    = (b != '0) && (hold || (spur && $urandom_range(0, 2) == 0));
            bus.dividend = N'($urandom);
            bus.divisor  = N'($urandom);
            @(negedge clk);
        end
        check("busy_at_finish", 64'(bus.busy), 64'(0));
        if (!hold) begin
            bus.start = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    // Reset mid-run: outputs clear at once and the aborted operation never finishes.
    task automatic reset_mid_run();
        int unsigned acc;
        bus.start    = 1'b1;
        bus.dividend = N'(65535);
        bus.divisor  = N'(255);
        acc = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < acc + 6) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_quotient",  64'(bus.quotient),    64'(0));
        check("rst_remainder", 64'(bus.remainder),   64'(0));
        check("rst_finish",    64'(bus.finish),      64'(0));
        check("rst_busy",      64'(bus.busy),        64'(0));
        check("rst_dbz",       64'(bus.div_by_zero), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (N + 4) @(negedge clk);
        check("post_rst_busy", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset_quotient",  64'(bus.quotient),    64'(0));
        check("reset_remainder", 64'(bus.remainder),   64'(0));
        check("reset_finish",    64'(bus.finish),      64'(0));
        check("reset_busy",      64'(bus.busy),        64'(0));
        check("reset_dbz",       64'(bus.div_by_zero), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        do_op(N'(200), N'(7), 1, 1'b0, 1'b0);
        do_op(N'(5),   N'(9), 0, 1'b0, 1'b0);
        do_op(N'(13),  N'(0), 1, 1'b0, 1'b0);
        do_op(N'(20),  N'(5), 2, 1'b0, 1'b0);
        reset_mid_run();
        do_op(N'(1000), N'(3), 1, 1'b0, 1'b0);
        do_op(N'(50000), N'(123), 0, 1'b0, 1'b1);
        do_op(N'(777),   N'(10),  1, 1'b0, 1'b0);
        do_op(N'(65535), N'(1),     0, 1'b1, 1'b0);
        do_op(N'(0),     N'(7),     0, 1'b0, 1'b0);
        do_op(N'(65535), N'(65535), 1, 1'b1, 1'b0);
        do_op(N'(1),     N'(65535), 0, 1'b0, 1'b0);
        do_op(N'(32768), N'(2),     0, 1'b0, 1'b0);
        do_op(N'(0),     N'(0),     0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            a = N'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = N'($urandom_range(1, 15));
                default: b = N'($urandom);
            endcase
            do_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  (b != '0) && ($urandom_range(0, 3) == 0));
        end
        bus.start = 1'b0;

        for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
